// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that hands a single FIFO write port to one of NUM_REQ
// requesters for bursts of up to MAX_BURST words, with same-edge regrant on release.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            w_Clk,
  input  logic                            w_Rst,
  input  logic [NUM_REQ-1:0]              req_Valid,
  input  logic [NUM_REQ-1:0]              req_Last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_Data,
  output logic [NUM_REQ-1:0]              req_Ready,
  input  logic                            fifo_Full,
  output logic                            w_Inc,
  output logic [DATA_WIDTH-1:0]           w_Data,
  output logic                            grant_Valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_Id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [ID_W:0]    NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ID_W-1:0]   rr_base, rr_id;
  logic [ID_W:0]     rr_idx;
  logic              rr_any;
  logic              cur_valid, cur_last, release_now;

  // Walk from the farthest candidate to the nearest so the first requester after
  // rr_base wins; the base itself comes last, so it only wins when it is alone.
  always_comb begin
    rr_base = (state_q == BURST) ? grant_id_q : last_id_q;
    rr_any  = |req_Valid;
    rr_id   = '0;
    rr_idx  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      rr_idx = {1'b0, rr_base} + (ID_W+1)'(off);
      if (rr_idx >= NUM_REQ_X) rr_idx = rr_idx - NUM_REQ_X;
      if (req_Valid[rr_idx[ID_W-1:0]]) rr_id = rr_idx[ID_W-1:0];
    end
  end

  always_comb begin
    cur_valid   = req_Valid[grant_id_q];
    cur_last    = req_Last[grant_id_q];
    grant_Valid = (state_q == BURST);
    w_Inc       = grant_Valid & cur_valid & ~fifo_Full;
    req_Ready   = '0;
    w_Data      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_Valid && grant_id_q == ID_W'(i)) begin
        req_Ready[i] = ~fifo_Full;
        w_Data       = req_Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Abandon (granted requester not valid) releases even while the FIFO is full.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    last_id_d   = last_id_q;
    cnt_d       = cnt_q;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d    = BURST;
          grant_id_d = rr_id;
          cnt_d      = '0;
        end
      end
      BURST: begin
        release_now = !cur_valid || (w_Inc && (cur_last || cnt_q == CNT_LAST));
        if (w_Inc) cnt_d = cnt_q + 1'b1;
        if (release_now) begin
          last_id_d = grant_id_q;
          cnt_d     = '0;
          if (rr_any) grant_id_d = rr_id;
          else        state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_Clk or negedge w_Rst) begin
    if (!w_Rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant_Id = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed scenarios plus a long random run,
// checked against a transaction-level round-robin model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            w_Clk = 1'b0;
  logic            w_Rst;
  logic [N-1:0]    req_Valid, req_Last, req_Ready;
  logic [N*DW-1:0] req_Data;
  logic            fifo_Full, w_Inc, grant_Valid;
  logic [DW-1:0]   w_Data;
  logic [1:0]      grant_Id;

  always #5 w_Clk = ~w_Clk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .w_Clk(w_Clk), .w_Rst(w_Rst),
    .req_Valid(req_Valid), .req_Last(req_Last), .req_Data(req_Data),
    .req_Ready(req_Ready), .fifo_Full(fifo_Full),
    .w_Inc(w_Inc), .w_Data(w_Data),
    .grant_Valid(grant_Valid), .grant_Id(grant_Id)
  );

  typedef struct { bit gv; int id; int rdy; bit winc; } cyc_t;
  typedef struct { int id; int data; } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];
  int   total = 0;
  int   bad   = 0;
  int   seq[N];
  int   wait_x[N];
  int   max_wait = 0;

  bit   m_busy;
  int   m_owner, m_count, m_prev;

  function automatic int mkword(int i, int s);
    return ((i & 7) << 5) | (s & 31);
  endfunction

  function automatic int rr_pick(int vld, int base);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (base + k) % N;
      if (((vld >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_busy  = 1'b0;
    m_prev  = N - 1;
    m_owner = 0;
    m_count = 0;
    cyc_q.delete();
    wr_q.delete();
  endtask

  // Drive one cycle of inputs, then predict what the arbiter shows during that cycle
  // and advance the model to the state it should hold after the next edge.
  task automatic applyStimulus(input int v, input int l, input bit f);
    cyc_t e;
    wr_t  w;
    int   word, nxt;
    bit   vo, lo;
    @(posedge w_Clk);
    #1;
    req_Valid = v[N-1:0];
    req_Last  = l[N-1:0];
    fifo_Full = f;
    for (int i = 0; i < N; i++) begin
      word = mkword(i, seq[i]);
      req_Data[i*DW +: DW] = word[DW-1:0];
    end
    e.gv = m_busy; e.id = m_owner; e.rdy = 0; e.winc = 1'b0;
    if (m_busy) begin
      vo = ((v >> m_owner) & 1) == 1;
      lo = ((l >> m_owner) & 1) == 1;
      if (!f) e.rdy = 1 << m_owner;
      e.winc = vo && !f;
      if (e.winc) begin
        w.id = m_owner;
        w.data = mkword(m_owner, seq[m_owner]);
        wr_q.push_back(w);
        seq[m_owner]++;
        m_count++;
      end
      if (!vo || (e.winc && (lo || m_count == MB))) begin
        m_prev = m_owner;
        nxt = rr_pick(v, m_owner);
        if (nxt < 0) m_busy = 1'b0;
        else begin m_owner = nxt; m_count = 0; end
      end
    end else begin
      nxt = rr_pick(v, m_prev);
      if (nxt >= 0) begin m_busy = 1'b1; m_owner = nxt; m_count = 0; end
    end
    cyc_q.push_back(e);
  endtask

  // Monitor: compares each driven cycle and every observed write against the queues.
  always @(negedge w_Clk) begin
    cyc_t e;
    wr_t  w;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      checkOutput("grant_valid", grant_Valid, e.gv);
      if (e.gv) checkOutput("grant_id", grant_Id, e.id);
      checkOutput("req_ready", req_Ready, e.rdy);
      checkOutput("w_inc", w_Inc, e.winc);
      if (!e.gv) checkOutput("idle_wdata", w_Data, 0);
    end
    if (w_Inc === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_write: got id %0d data %0d expected no write", grant_Id, w_Data);
      end else begin
        w = wr_q.pop_front();
        checkOutput("write_id", grant_Id, w.id);
        checkOutput("write_data", w_Data, w.data);
      end
    end
    checkOutput("write_while_full", w_Inc & fifo_Full, 0);
    checkOutput("ready_onehot", $countones(req_Ready) <= 1, 1);
    for (int i = 0; i < N; i++) begin
      if (!w_Rst || !req_Valid[i] || (grant_Valid && grant_Id == i)) wait_x[i] = 0;
      else if (w_Inc) wait_x[i]++;
      if (wait_x[i] > max_wait) max_wait = wait_x[i];
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start, cyc, v, l;
    bit f;
    for (int i = 0; i < N; i++) begin seq[i] = 0; wait_x[i] = 0; end
    modelReset();
    w_Rst = 1'b0; req_Valid = '1; req_Last = '0; req_Data = '0; fifo_Full = 1'b0;
    #2;
    checkOutput("reset_grant_valid", grant_Valid, 0);
    checkOutput("reset_w_inc", w_Inc, 0);
    checkOutput("reset_req_ready", req_Ready, 0);
    checkOutput("reset_w_data", w_Data, 0);
    checkOutput("reset_grant_id", grant_Id, 0);
    req_Valid = '0;
    @(posedge w_Clk); #1; w_Rst = 1'b1;

    // All requesters streaming without last: 4-word bursts rotating 0,1,2,3,0.
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(4'hF, 0, 1'b0);
      #2;
      if (k == 0) checkOutput("rr_first_cycle_idle", grant_Valid, 0);
      else begin
        checkOutput("rr_burst_id", grant_Id, ((k - 1) / 4) % 4);
        checkOutput("rr_burst_winc", w_Inc, 1);
      end
    end
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    // Single requester, three words, last on the third.
    start = seq[0]; cyc = 0;
    while (seq[0] != start + 3 && cyc < 10) begin
      applyStimulus(1, (seq[0] == start + 2) ? 1 : 0, 1'b0);
      cyc++;
    end
    checkOutput("single_cycles", cyc, 4);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);
    #2 checkOutput("single_idle_after", grant_Valid, 0);

    // FIFO full for five cycles while the second word is pending.
    start = seq[1]; cyc = 0;
    while (seq[1] != start + 3 && cyc < 16) begin
      f = (cyc >= 2 && cyc <= 6);
      applyStimulus(2, (seq[1] == start + 2) ? 2 : 0, f);
      #2;
      if (f) begin
        checkOutput("stall_winc", w_Inc, 0);
        checkOutput("stall_ready", req_Ready, 0);
        checkOutput("stall_grant", {grant_Valid, grant_Id}, {1'b1, 2'd1});
      end
      cyc++;
    end
    checkOutput("stall_cycles", cyc, 9);
    checkOutput("stall_words", seq[1] - start, 3);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    // Requester 1 abandons after one word while requester 2 waits.
    applyStimulus(2, 0, 1'b0);
    applyStimulus(2, 0, 1'b0);
    applyStimulus(4, 0, 1'b0);
    applyStimulus(4, 0, 1'b0);
    #2;
    checkOutput("abandon_regrant_valid", grant_Valid, 1);
    checkOutput("abandon_regrant_id", grant_Id, 2);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    // Reset in the middle of requester 3's burst.
    applyStimulus(8, 0, 1'b0);
    applyStimulus(8, 0, 1'b0);
    applyStimulus(8, 0, 1'b0);
    @(negedge w_Clk); #2;
    w_Rst = 1'b0;
    #1;
    checkOutput("midreset_grant_valid", grant_Valid, 0);
    checkOutput("midreset_w_inc", w_Inc, 0);
    checkOutput("midreset_req_ready", req_Ready, 0);
    checkOutput("midreset_w_data", w_Data, 0);
    req_Valid = '0;
    repeat (2) @(posedge w_Clk);
    #1; w_Rst = 1'b1;
    modelReset();
    applyStimulus(10, 0, 1'b0);
    applyStimulus(10, 0, 1'b0);
    #2 checkOutput("post_reset_first_grant", grant_Id, 1);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    // Random valid/last/full traffic.
    v = 0;
    for (int c = 0; c < 10000; c++) begin
      int nv;
      nv = 0; l = 0;
      for (int i = 0; i < N; i++) begin
        if (((v >> i) & 1) == 1) begin
          if ($urandom_range(15) != 0) nv |= (1 << i);
        end else if ($urandom_range(2) == 0) nv |= (1 << i);
        if ($urandom_range(3) == 0) l |= (1 << i);
      end
      v = nv;
      f = ($urandom_range(5) == 0);
      applyStimulus(v, l, f);
    end

    repeat (3) applyStimulus(0, 0, 1'b0);
    @(negedge w_Clk); #1;
    checkOutput("cycle_queue_drained", cyc_q.size(), 0);
    checkOutput("write_queue_drained", wr_q.size(), 0);
    checkOutput("starvation_bound", max_wait <= (N - 1) * MB, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
